mouse_ps2_rx: RTL and testbench
===============================

MOUSE_PS2_RX -- requirements
Module: mouse_ps2_rx

Interface
REQ-001 SHALL have parameter H_MAX, default 640, meaning horizontal position count; X range is 0..H_MAX-1.
REQ-002 SHALL have parameter V_MAX, default 480, meaning vertical position count; Y range is 0..V_MAX-1.
REQ-003 SHALL have parameter X_INIT, default 320, meaning the X value at reset.
REQ-004 SHALL have parameter Y_INIT, default 240, meaning the Y value at reset.
REQ-005 SHALL have parameter TIMEOUT, default 5000, meaning the number of clk cycles without a ps2_clk falling edge after which a partial frame is aborted.
REQ-006 SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port ps2_clk, input, 1 bit: raw, asynchronous PS/2 clock from the mouse.
REQ-009 SHALL have port ps2_data, input, 1 bit: raw, asynchronous PS/2 data from the mouse.
REQ-010 SHALL have port Mouse_X, output, 16 bits: pointer X position.
REQ-011 SHALL have port Mouse_Y, output, 16 bits: pointer Y position.
REQ-012 SHALL have port Mouse_Click, output, 8 bits: {5'b0, middle, right, left} button state.
REQ-013 SHALL have port pkt_valid, output, 1 bit: one-cycle pulse when a packet is applied.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse on a parity, stop, sync or timeout error.

Function
REQ-015 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers; a falling edge is sync_prev=1 and sync_cur=0.
REQ-016 SHALL sample synchronized ps2_data only on detected falling edges.
REQ-017 SHALL implement frame FSM states IDLE, DATA, PARITY and STOP.
REQ-018 In IDLE, SHALL go to DATA on a sampled 0 (start bit) and SHALL ignore a sampled 1.
REQ-019 In DATA, SHALL shift in 8 bits LSB first, then go to PARITY.
REQ-020 In PARITY, SHALL check odd parity over data plus parity bit, then go to STOP.
REQ-021 In STOP, SHALL require the sampled bit to be 1, then return to IDLE.
REQ-022 SHALL accept a byte only if both parity and stop are correct; otherwise it SHALL pulse err, discard the byte and reset the byte index to 0.
REQ-023 SHALL count clk cycles since the last falling edge while not in IDLE; on reaching TIMEOUT it SHALL pulse err, go to IDLE and reset the byte index to 0.
REQ-024 SHALL assemble packet bytes b0, b1 and b2 using a byte index 0..2 that wraps to 0 after b2.
REQ-025 SHALL accept b0 only if b0[3]=1; otherwise it SHALL pulse err, discard the byte and keep the index at 0 (resync).
REQ-026 SHALL form dx as the 9-bit signed value {b0[4], b1} and dy as the 9-bit signed value {b0[5], b2}.
REQ-027 If b0[6]=1 (X overflow), SHALL treat dx as 0; if b0[7]=1 (Y overflow), SHALL treat dy as 0.
REQ-028 SHALL compute X_new = X + dx and Y_new = Y - dy (screen Y grows downward) in 17-bit signed arithmetic.
REQ-029 SHALL clamp results below 0 to 0, X above H_MAX-1 to H_MAX-1, and Y above V_MAX-1 to V_MAX-1.
REQ-030 On the clk edge following acceptance of b2, SHALL update Mouse_X, Mouse_Y and Mouse_Click = {5'b0, b0[2], b0[1], b0[0]}, and SHALL assert pkt_valid for exactly that one cycle.
REQ-031 Outputs SHALL hold their values between packets.
REQ-032 pkt_valid and err SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-033 While rst=1 at a clk edge, the block SHALL set: Mouse_X=X_INIT; Mouse_Y=Y_INIT; Mouse_Click=0; pkt_valid=0; err=0; FSM=IDLE; byte index=0; timeout counter=0; synchronizers=1 (idle line).
REQ-034 Reset asserted mid-frame or mid-packet SHALL discard all partial data, with no pkt_valid and no err pulse.

Verification
REQ-035 Packet 0x08, 0x05, 0x03 from reset -> one pkt_valid pulse; Mouse_X=325, Mouse_Y=237, Mouse_Click=0.
REQ-036 Packet 0x19, 0xF6, 0x00 (dx=-10, left button) -> Mouse_X=310, Mouse_Click=0x01; then 0x09, 0x00, 0x00 -> Mouse_X still 310, Mouse_Click=0x01.
REQ-037 Starting from reset, 40 packets of 0x08, 0x7F, 0x00 -> Mouse_X saturates at 639 and never wraps; packets of 0x18, 0x80, 0x00 -> Mouse_X reaches 0 and holds.
REQ-038 Byte with bad parity as b1 -> err pulse, no pkt_valid; next valid 3-byte packet is applied correctly.
REQ-039 Stream 0x00 (b0[3]=0), then a valid packet -> err pulse on 0x00, then pkt_valid with correct values.
REQ-040 Frame stopped after 4 data bits, ps2_clk held high for more than TIMEOUT cycles -> err pulse, FSM returns to IDLE; next full packet is decoded correctly; rst pulse mid-packet -> outputs return to 320/240/0.

Source files
------------

// File: rtl/mouse_ps2_rx.sv
// PS/2 mouse receiver: decodes 11-bit PS/2 frames (start, 8 data LSB first, odd parity,
// stop) into 3-byte mouse packets and integrates the movement into a clamped pointer
// position.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   ps2_clk      raw asynchronous PS/2 clock from the mouse
//   ps2_data     raw asynchronous PS/2 data from the mouse
//   Mouse_X      pointer X position, 0..H_MAX-1
//   Mouse_Y      pointer Y position, 0..V_MAX-1
//   Mouse_Click  {5'b0, middle, right, left}
//   pkt_valid    one-cycle pulse when a packet is applied to the outputs
//   err          one-cycle pulse on parity, stop, sync or timeout error
module mouse_ps2_rx #(
  parameter int unsigned H_MAX   = 640,
  parameter int unsigned V_MAX   = 480,
  parameter int unsigned X_INIT  = 320,
  parameter int unsigned Y_INIT  = 240,
  parameter int unsigned TIMEOUT = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] Mouse_X,
  output logic [15:0] Mouse_Y,
  output logic [7:0]  Mouse_Click,
  output logic        pkt_valid,
  output logic        err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic signed [16:0] XMax = 17'(H_MAX - 1);
  localparam logic signed [16:0] YMax = 17'(V_MAX - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Synchronizers: ps2c_sync_q = {prev, cur, first stage}
  logic [2:0]      ps2c_sync_q, ps2c_sync_d;
  logic [1:0]      ps2d_sync_q, ps2d_sync_d;
  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_ok_q, par_ok_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [1:0]      idx_q, idx_d;
  // Fields of b0 and the full b1 kept until b2 arrives
  logic [2:0]      btn_q, btn_d;
  logic            x_sign_q, x_sign_d;
  logic            y_sign_q, y_sign_d;
  logic            x_ovf_q, x_ovf_d;
  logic            y_ovf_q, y_ovf_d;
  logic [7:0]      b1_q, b1_d;
  logic [15:0]     x_q, x_d;
  logic [15:0]     y_q, y_d;
  logic [2:0]      click_q, click_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic            err_q, err_d;

  logic               fall;
  logic               bit_in;
  logic signed [16:0] dx, dy, x_sum, y_sum;
  logic [15:0]        x_clamp, y_clamp;

  assign fall   = ps2c_sync_q[2] & ~ps2c_sync_q[1];
  assign bit_in = ps2d_sync_q[1];

  // Movement arithmetic; shift_q holds b2 while the stop bit of b2 is being sampled
  always_comb begin
    dx    = x_ovf_q ? 17'sd0 : {{8{x_sign_q}}, x_sign_q, b1_q};
    dy    = y_ovf_q ? 17'sd0 : {{8{y_sign_q}}, y_sign_q, shift_q};
    x_sum = $signed({1'b0, x_q}) + dx;
    y_sum = $signed({1'b0, y_q}) - dy;

    if (x_sum < 17'sd0)     x_clamp = 16'd0;
    else if (x_sum > XMax)  x_clamp = XMax[15:0];
    else                    x_clamp = x_sum[15:0];

    if (y_sum < 17'sd0)     y_clamp = 16'd0;
    else if (y_sum > YMax)  y_clamp = YMax[15:0];
    else                    y_clamp = y_sum[15:0];
  end

  always_comb begin
    ps2c_sync_d = {ps2c_sync_q[1:0], ps2_clk};
    ps2d_sync_d = {ps2d_sync_q[0], ps2_data};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    tmo_d       = tmo_q;
    idx_d       = idx_q;
    btn_d       = btn_q;
    x_sign_d    = x_sign_q;
    y_sign_d    = y_sign_q;
    x_ovf_d     = x_ovf_q;
    y_ovf_d     = y_ovf_q;
    b1_d        = b1_q;
    x_d         = x_q;
    y_d         = y_q;
    click_d     = click_q;
    pkt_valid_d = 1'b0;
    err_d       = 1'b0;

    if (state_q == StIdle || fall) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if (state_q != StIdle && !fall && tmo_q == TmoW'(TIMEOUT - 1)) begin
      // Partial frame abandoned by the mouse
      err_d   = 1'b1;
      state_d = StIdle;
      idx_d   = 2'd0;
      tmo_d   = '0;
    end else if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!bit_in) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_ok_d = ^{shift_q, bit_in};
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (bit_in && par_ok_q) begin
            unique case (idx_q)
              2'd0: begin
                // b0 always has bit 3 set; anything else means we are out of sync
                if (shift_q[3]) begin
                  btn_d    = shift_q[2:0];
                  x_sign_d = shift_q[4];
                  y_sign_d = shift_q[5];
                  x_ovf_d  = shift_q[6];
                  y_ovf_d  = shift_q[7];
                  idx_d    = 2'd1;
                end else begin
                  err_d = 1'b1;
                end
              end
              2'd1: begin
                b1_d  = shift_q;
                idx_d = 2'd2;
              end
              2'd2: begin
                x_d         = x_clamp;
                y_d         = y_clamp;
                click_d     = btn_q;
                pkt_valid_d = 1'b1;
                idx_d       = 2'd0;
              end
              default: idx_d = 2'd0;
            endcase
          end else begin
            err_d = 1'b1;
            idx_d = 2'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps2c_sync_q <= 3'b111;
      ps2d_sync_q <= 2'b11;
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      par_ok_q    <= 1'b0;
      tmo_q       <= '0;
      idx_q       <= 2'd0;
      btn_q       <= 3'd0;
      x_sign_q    <= 1'b0;
      y_sign_q    <= 1'b0;
      x_ovf_q     <= 1'b0;
      y_ovf_q     <= 1'b0;
      b1_q        <= 8'd0;
      x_q         <= 16'(X_INIT);
      y_q         <= 16'(Y_INIT);
      click_q     <= 3'd0;
      pkt_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ps2c_sync_q <= ps2c_sync_d;
      ps2d_sync_q <= ps2d_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      tmo_q       <= tmo_d;
      idx_q       <= idx_d;
      btn_q       <= btn_d;
      x_sign_q    <= x_sign_d;
      y_sign_q    <= y_sign_d;
      x_ovf_q     <= x_ovf_d;
      y_ovf_q     <= y_ovf_d;
      b1_q        <= b1_d;
      x_q         <= x_d;
      y_q         <= y_d;
      click_q     <= click_d;
      pkt_valid_q <= pkt_valid_d;
      err_q       <= err_d;
    end
  end

  assign Mouse_X     = x_q;
  assign Mouse_Y     = y_q;
  assign Mouse_Click = {5'b0, click_q};
  assign pkt_valid   = pkt_valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mouse_ps2_rx.sv
module tb_mouse_ps2_rx;

  localparam int unsigned Tmo = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] mouse_x, mouse_y;
  logic [7:0]  mouse_click;
  logic        pkt_valid, err;

  mouse_ps2_rx #(
    .H_MAX  (640),
    .V_MAX  (480),
    .X_INIT (320),
    .Y_INIT (240),
    .TIMEOUT(Tmo)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .Mouse_X    (mouse_x),
    .Mouse_Y    (mouse_y),
    .Mouse_Click(mouse_click),
    .pkt_valid  (pkt_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pv_cnt   = 0;
  int err_cnt  = 0;
  int dbl_cnt  = 0;
  logic pv_prev = 1'b0, err_prev = 1'b0;

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (pkt_valid) pv_cnt++;
    if (err) err_cnt++;
    if ((pkt_valid && pv_prev) || (err && err_prev)) dbl_cnt++;
    pv_prev  = pkt_valid;
    err_prev = err;
  end

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         x, y;
    int         click;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    clks(4);
    ps2_clk = 1'b0;
    clks(8);
    ps2_clk = 1'b1;
    clks(4);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_frame(b0, 1'b0, 1'b0);
    send_frame(b1, 1'b0, 1'b0);
    send_frame(b2, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clks(3);
    rst = 1'b0;
    clks(2);
  endtask

  task automatic check_out(input string name, input int x, input int y, input int click);
    check({name, " X"}, int'(mouse_x), x);
    check({name, " Y"}, int'(mouse_y), y);
    check({name, " click"}, int'(mouse_click), click);
  endtask

  initial begin
    int pv0, err0, ex;

    vecs[0] = '{8'h08, 8'h05, 8'h03, 325, 237, 0};
    vecs[1] = '{8'h19, 8'hF6, 8'h00, 315, 237, 1};
    vecs[2] = '{8'h09, 8'h00, 8'h00, 315, 237, 1};
    vecs[3] = '{8'h28, 8'h00, 8'h05, 315, 479, 0};
    vecs[4] = '{8'h08, 8'h00, 8'hF0, 315, 239, 0};
    vecs[5] = '{8'h48, 8'hFF, 8'h00, 315, 239, 0};
    vecs[6] = '{8'h88, 8'h0A, 8'hFF, 325, 239, 0};
    vecs[7] = '{8'h0E, 8'h00, 8'h00, 325, 239, 6};
    vecs[8] = '{8'h38, 8'hEC, 8'h14, 305, 475, 0};

    do_reset();
    check_out("reset", 320, 240, 0);
    check("reset pkt_valid", pv_cnt, 0);
    check("reset err", err_cnt, 0);

    // Table-driven packets, each from the previous position
    for (int i = 0; i < 9; i++) begin
      pv0  = pv_cnt;
      err0 = err_cnt;
      send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      check_out($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].click);
      check($sformatf("vec%0d pkt_valid pulses", i), pv_cnt - pv0, 1);
      check($sformatf("vec%0d err pulses", i), err_cnt - err0, 0);
    end

    // Saturation at the right edge, then at the left edge
    do_reset();
    ex = 320;
    for (int i = 0; i < 40; i++) begin
      send_pkt(8'h08, 8'h7F, 8'h00);
      ex = (ex + 127 > 639) ? 639 : ex + 127;
      check($sformatf("sat right %0d", i), int'(mouse_x), ex);
    end
    for (int i = 0; i < 8; i++) begin
      send_pkt(8'h18, 8'h80, 8'h00);
      ex = (ex - 128 < 0) ? 0 : ex - 128;
      check($sformatf("sat left %0d", i), int'(mouse_x), ex);
    end
    check("sat Y", int'(mouse_y), 240);

    // Bad parity on b1
    pv0 = pv_cnt; err0 = err_cnt;
    send_frame(8'h08, 1'b0, 1'b0);
    send_frame(8'h05, 1'b1, 1'b0);
    check("bad parity err", err_cnt - err0, 1);
    check("bad parity pkt_valid", pv_cnt - pv0, 0);
    send_pkt(8'h08, 8'h05, 8'h03);
    check_out("after parity", 5, 237, 0);
    check("after parity pkt_valid", pv_cnt - pv0, 1);

    // Bad stop bit on b1
    pv0 = pv_cnt; err0 = err_cnt;
    send_frame(8'h08, 1'b0, 1'b0);
    send_frame(8'h08, 1'b0, 1'b1);
    check("bad stop err", err_cnt - err0, 1);
    send_pkt(8'h08, 8'h01, 8'h01);
    check_out("after stop", 6, 236, 0);
    check("after stop pkt_valid", pv_cnt - pv0, 1);

    // Out-of-sync first byte
    pv0 = pv_cnt; err0 = err_cnt;
    send_frame(8'h00, 1'b0, 1'b0);
    check("sync err", err_cnt - err0, 1);
    check("sync pkt_valid", pv_cnt - pv0, 0);
    send_pkt(8'h08, 8'h01, 8'h01);
    check_out("after sync", 7, 235, 0);
    check("after sync err", err_cnt - err0, 1);

    // Timeout after b0 plus a partial frame; byte index must restart
    pv0 = pv_cnt; err0 = err_cnt;
    send_frame(8'h08, 1'b0, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    clks(Tmo + 20);
    check("timeout err", err_cnt - err0, 1);
    check("timeout pkt_valid", pv_cnt - pv0, 0);
    send_pkt(8'h08, 8'h02, 8'h02);
    check_out("after timeout", 9, 233, 0);
    check("after timeout pkt_valid", pv_cnt - pv0, 1);

    // Reset mid-packet and mid-frame
    pv0 = pv_cnt; err0 = err_cnt;
    send_frame(8'h19, 1'b0, 1'b0);
    send_frame(8'h03, 1'b0, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    do_reset();
    check_out("mid reset", 320, 240, 0);
    clks(Tmo + 20);
    check("mid reset pkt_valid", pv_cnt - pv0, 0);
    check("mid reset err", err_cnt - err0, 0);
    send_pkt(8'h19, 8'hF6, 8'h00);
    check_out("left click", 310, 240, 1);
    send_pkt(8'h09, 8'h00, 8'h00);
    check_out("hold click", 310, 240, 1);
    check("post reset pkt_valid", pv_cnt - pv0, 2);

    check("single-cycle pulses", dbl_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
